// File: rtl/imem_fetch_ctrl.sv
// Fetch-stage controller: owns the PC, issues one-word instruction reads and queues fetched words for ID.
// Define IMEM_LOADER_EN to add boot-loader write access to the instruction-memory port.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
`ifdef IMEM_LOADER_EN
    input  logic        if_ready,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    output logic        imem_we,
    output logic [31:0] imem_wdata
`else
    input  logic        if_ready
`endif
);

    localparam int unsigned AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned OW = $clog2(QDEPTH + 1);
    localparam int unsigned LW = OW + 1;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1
`ifdef IMEM_LOADER_EN
        ,
        ST_LOAD  = 2'd2
`endif
    } state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    state_t      state_r;
    state_t      state_s;
    logic [31:0] fetch_pc_r;
    logic [31:0] fetch_pc_s;
    logic        inflight_r;
    logic [31:0] req_pc_r;
    logic [OW-1:0] occ_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [31:0] pc_q_r    [QDEPTH];
    logic [31:0] instr_q_r [QDEPTH];

    logic        issue_s;
    logic        flush_s;
    logic        push_s;
    logic        pop_s;
    logic        head_valid_s;
    logic [LW-1:0] level_s;
    logic        req_s;
    logic [31:0] addr_s;
`ifdef IMEM_LOADER_EN
    logic        we_s;
    logic [31:0] wdata_s;
    logic        ld_ready_s;
`endif

    assign head_valid_s = (occ_r != OW'(0));
    assign pop_s        = head_valid_s & if_ready;
    // Projected queue usage if a read were issued now; a pop this cycle frees a slot.
    assign level_s      = {1'b0, occ_r} + LW'(inflight_r) - LW'(pop_s);
    // A response arriving in a flush cycle is the killed in-flight read.
    assign push_s       = inflight_r & ~flush_s;

    // Next-state, issue decision and memory-port drive.
    always_comb begin
        state_s    = state_r;
        fetch_pc_s = fetch_pc_r;
        issue_s    = 1'b0;
        flush_s    = 1'b0;
        req_s      = 1'b0;
        addr_s     = 32'h0000_0000;
`ifdef IMEM_LOADER_EN
        we_s       = 1'b0;
        wdata_s    = 32'h0000_0000;
        ld_ready_s = 1'b0;
`endif
        case (state_r)
            ST_BOOT: begin
                if (redirect_valid) begin
                    fetch_pc_s = word_align(redirect_pc);
                end else begin
                    fetch_pc_s = fetch_pc_r;
                end
`ifdef IMEM_LOADER_EN
                if (ld_valid) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_FETCH;
                end
`else
                state_s = ST_FETCH;
`endif
            end
            ST_FETCH: begin
                if (redirect_valid) begin
                    flush_s    = 1'b1;
                    fetch_pc_s = word_align(redirect_pc);
                end
`ifdef IMEM_LOADER_EN
                else if (ld_valid) begin
                    // Stop issuing and hand the port over once the last read has returned.
                    if (!inflight_r) begin
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end
`endif
                else if (level_s < LW'(QDEPTH)) begin
                    issue_s    = 1'b1;
                    req_s      = 1'b1;
                    addr_s     = fetch_pc_r;
                    fetch_pc_s = fetch_pc_r + 32'd4;
                end else begin
                    issue_s = 1'b0;
                end
            end
`ifdef IMEM_LOADER_EN
            ST_LOAD: begin
                ld_ready_s = 1'b1;
                if (ld_valid) begin
                    req_s   = 1'b1;
                    we_s    = 1'b1;
                    addr_s  = word_align(ld_addr);
                    wdata_s = ld_data;
                end else begin
                    state_s    = ST_FETCH;
                    flush_s    = 1'b1;
                    fetch_pc_s = RESET_PC;
                end
            end
`endif
            default: begin
                state_s    = ST_BOOT;
                flush_s    = 1'b1;
                fetch_pc_s = RESET_PC;
            end
        endcase
    end

    // FSM state, fetch PC and in-flight read tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_BOOT;
            fetch_pc_r <= RESET_PC;
            inflight_r <= 1'b0;
            req_pc_r   <= 32'h0000_0000;
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            inflight_r <= issue_s;
            if (issue_s) begin
                req_pc_r <= fetch_pc_r;
            end
        end
    end

    // Instruction queue storage and pointers; a flush empties it in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_r    <= OW'(0);
            rd_ptr_r <= AW'(0);
            wr_ptr_r <= AW'(0);
            for (int i = 0; i < QDEPTH; i++) begin
                pc_q_r[i]    <= 32'h0000_0000;
                instr_q_r[i] <= 32'h0000_0000;
            end
        end else if (flush_s) begin
            occ_r    <= OW'(0);
            rd_ptr_r <= AW'(0);
            wr_ptr_r <= AW'(0);
        end else begin
            if (push_s) begin
                pc_q_r[wr_ptr_r]    <= req_pc_r;
                instr_q_r[wr_ptr_r] <= imem_rdata;
                wr_ptr_r            <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            occ_r <= occ_r + OW'(push_s) - OW'(pop_s);
        end
    end

    assign imem_req  = req_s;
    assign imem_addr = addr_s;
    assign if_valid  = head_valid_s;
    assign if_pc     = head_valid_s ? pc_q_r[rd_ptr_r]    : 32'h0000_0000;
    assign if_instr  = head_valid_s ? instr_q_r[rd_ptr_r] : 32'h0000_0000;
`ifdef IMEM_LOADER_EN
    assign ld_ready   = ld_ready_s;
    assign imem_we    = we_s;
    assign imem_wdata = wdata_s;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: cycle vector table plus a transfer scoreboard against a word-addressed memory model.
module tb_imem_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        mem_we;
`ifdef IMEM_LOADER_EN
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        imem_we;
    logic [31:0] imem_wdata;
    assign mem_we = imem_we;
`else
    assign mem_we = 1'b0;
`endif

    imem_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
`ifdef IMEM_LOADER_EN
        .if_ready       (if_ready),
        .ld_valid       (ld_valid),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .ld_ready       (ld_ready),
        .imem_we        (imem_we),
        .imem_wdata     (imem_wdata)
`else
        .if_ready       (if_ready)
`endif
    );

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } xfer_t;

    xfer_t       sb_q[$];
    int          checks   = 0;
    int          errors   = 0;
    int          we_count = 0;
    bit          loaded   = 1'b0;
    logic [31:0] mem [64];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_word(input int idx);
        case (idx)
            0:       return 32'h0000_0093;
            1:       return 32'h0010_0113;
            default: return {19'd0, 6'(idx), 7'h13};
        endcase
    endfunction

    function automatic logic [31:0] golden(input logic [31:0] pc);
        if (loaded && pc == 32'h0000_0010) begin
            return 32'h0020_81B3;
        end
        return init_word(int'(pc[7:2]));
    endfunction

    function automatic vec_t mk(input logic rdy, input logic redir, input logic [31:0] rpc,
                                input logic req, input logic [31:0] addr,
                                input logic v, input logic [31:0] pc);
        vec_t t;
        t.rdy = rdy; t.redir = redir; t.rpc = rpc;
        t.exp_req = req; t.exp_addr = addr; t.exp_valid = v; t.exp_pc = pc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk_bit({tag, "_imem_req"}, imem_req, 1'b0);
        chk({tag, "_imem_addr"}, imem_addr, 32'h0);
        chk_bit({tag, "_if_valid"}, if_valid, 1'b0);
        chk({tag, "_if_pc"}, if_pc, 32'h0);
        chk({tag, "_if_instr"}, if_instr, 32'h0);
`ifdef IMEM_LOADER_EN
        chk_bit({tag, "_ld_ready"}, ld_ready, 1'b0);
        chk_bit({tag, "_imem_we"}, imem_we, 1'b0);
        chk({tag, "_imem_wdata"}, imem_wdata, 32'h0);
`endif
    endtask

    // Called at posedge+1: drives one cycle, checks at the negedge, returns at the next posedge+1.
    task automatic run_vec(input vec_t v, input string tag, input int idx);
        xfer_t e;
        if_ready       = v.rdy;
        redirect_valid = v.redir;
        redirect_pc    = v.rpc;
        if (v.rdy && v.exp_valid) begin
            e.pc    = v.exp_pc;
            e.instr = golden(v.exp_pc);
            sb_q.push_back(e);
        end
        @(negedge clk);
        chk_bit($sformatf("%s_req[%0d]", tag, idx), imem_req, v.exp_req);
        chk($sformatf("%s_addr[%0d]", tag, idx), imem_addr, v.exp_addr);
        chk_bit($sformatf("%s_valid[%0d]", tag, idx), if_valid, v.exp_valid);
        chk($sformatf("%s_pc[%0d]", tag, idx), if_pc, v.exp_pc);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    // Memory model: read data appears the cycle after the request; writes land at the request cycle.
    initial begin
        logic [31:0] pend_data;
        logic        pend;
        for (int i = 0; i < 64; i++) begin
            mem[i] = init_word(i);
        end
        forever begin
            @(negedge clk);
            pend      = imem_req & ~mem_we;
            pend_data = mem[imem_addr[7:2]];
`ifdef IMEM_LOADER_EN
            if (imem_req && mem_we) begin
                mem[imem_addr[7:2]] = imem_wdata;
                we_count++;
            end
`endif
            @(posedge clk);
            #1;
            imem_rdata = pend ? pend_data : 32'hDEAD_BEEF;
        end
    end

    // Scoreboard: every transfer to ID must match the oldest expected instruction.
    initial begin
        xfer_t e;
        forever begin
            @(negedge clk);
            if (rst_n && if_valid && if_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL xfer_unexpected actual_pc=%h required=no transfer", if_pc);
                end else begin
                    e = sb_q.pop_front();
                    if (if_pc !== e.pc || if_instr !== e.instr) begin
                        errors++;
                        $display("FAIL xfer actual=%h/%h required=%h/%h", if_pc, if_instr, e.pc, e.instr);
                    end
                end
            end
        end
    end

    initial begin
        vec_t tbl[26];
        vec_t rs[5];
        rst_n          = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_rdata     = 32'h0;
`ifdef IMEM_LOADER_EN
        ld_valid = 1'b0;
        ld_addr  = 32'h0;
        ld_data  = 32'h0;
`endif
        tbl[0]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0);
        tbl[1]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0);
        tbl[2]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         1'b0, 32'h0);
        tbl[3]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         1'b1, 32'h0);
        tbl[4]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'hC,         1'b1, 32'h4);
        for (int i = 5; i < 10; i++) begin
            tbl[i] = mk(1'b0, 1'b0, 32'h0,      1'b0, 32'h0,         1'b1, 32'h8);
        end
        tbl[10] = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h10,        1'b1, 32'h8);
        tbl[11] = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h14,        1'b1, 32'hC);
        tbl[12] = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h18,        1'b1, 32'h10);
        tbl[13] = mk(1'b1, 1'b1, 32'h40,        1'b0, 32'h0,         1'b1, 32'h14);
        tbl[14] = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h40,        1'b0, 32'h0);
        tbl[15] = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h44,        1'b0, 32'h0);
        tbl[16] = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h48,        1'b1, 32'h40);
        tbl[17] = mk(1'b1, 1'b1, 32'h43,        1'b0, 32'h0,         1'b1, 32'h44);
        tbl[18] = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h40,        1'b0, 32'h0);
        tbl[19] = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h44,        1'b0, 32'h0);
        tbl[20] = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h48,        1'b1, 32'h40);
        tbl[21] = mk(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b1, 32'h44);
        tbl[22] = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        tbl[23] = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0);
        tbl[24] = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'hFFFF_FFFC);
        tbl[25] = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         1'b1, 32'h0);
        rs[0]   = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0);
        rs[1]   = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0);
        rs[2]   = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         1'b0, 32'h0);
        rs[3]   = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         1'b1, 32'h0);
        rs[4]   = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'hC,         1'b1, 32'h4);

        #3;
        chk_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 26; i++) begin
            run_vec(tbl[i], "main", i);
        end

        // Asynchronous reset in the middle of streaming, then restart from RESET_PC.
        if_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_vec(rs[i], "restart", i);
        end

`ifdef IMEM_LOADER_EN
        begin
            vec_t lv[7];
            lv[0] = mk(1'b1, 1'b0, 32'h0, 1'b1, 32'h0,  1'b0, 32'h0);
            lv[1] = mk(1'b1, 1'b0, 32'h0, 1'b1, 32'h4,  1'b0, 32'h0);
            lv[2] = mk(1'b1, 1'b0, 32'h0, 1'b1, 32'h8,  1'b1, 32'h0);
            lv[3] = mk(1'b1, 1'b0, 32'h0, 1'b1, 32'hC,  1'b1, 32'h4);
            lv[4] = mk(1'b1, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 32'h8);
            lv[5] = mk(1'b1, 1'b0, 32'h0, 1'b1, 32'h14, 1'b1, 32'hC);
            lv[6] = mk(1'b1, 1'b0, 32'h0, 1'b1, 32'h18, 1'b1, 32'h10);
            rst_n    = 1'b0;
            ld_valid = 1'b1;
            ld_addr  = 32'h0000_0010;
            ld_data  = 32'h0020_81B3;
            we_count = 0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(negedge clk);
            chk_bit("ld_boot_ready", ld_ready, 1'b0);
            chk_bit("ld_boot_we", imem_we, 1'b0);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk_bit("ld_load_ready", ld_ready, 1'b1);
            chk_bit("ld_load_we", imem_we, 1'b1);
            chk_bit("ld_load_req", imem_req, 1'b1);
            chk("ld_load_addr", imem_addr, 32'h0000_0010);
            chk("ld_load_wdata", imem_wdata, 32'h0020_81B3);
            @(posedge clk);
            #1;
            ld_valid = 1'b0;
            @(negedge clk);
            chk_bit("ld_exit_we", imem_we, 1'b0);
            chk_bit("ld_exit_valid", if_valid, 1'b0);
            @(posedge clk);
            #1;
            loaded = 1'b1;
            for (int i = 0; i < 7; i++) begin
                run_vec(lv[i], "loader", i);
            end
            chk("ld_we_pulses", 32'(we_count), 32'd1);
        end
`endif

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
